// File: rtl/expr_tx.sv
// ASCII expression transmitter: serialises a latched digit/operator list as
// "d op d ... d[=]", one character per valid/ready beat.
module expr_tx #(
    parameter int MAX_TERMS = 4,
    parameter bit EMIT_EQ   = 1'b1,
    localparam int NT_W     = $clog2(MAX_TERMS + 1),
    localparam int OPS_W    = (MAX_TERMS > 1) ? 2 * (MAX_TERMS - 1) : 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [NT_W-1:0]        num_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [OPS_W-1:0]       ops,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_char,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIGIT = 3'd1,
        S_OP    = 3'd2,
        S_EQ    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NT_W-1:0]        idx_q, idx_d;
    logic [NT_W-1:0]        nt_q, nt_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [OPS_W-1:0]       ops_q, ops_d;
    logic                   err_q, err_d;
    logic [7:0]             char_q, char_d;

    logic                   req_bad_s;
    logic                   hs_s;
    logic [NT_W-1:0]        nxt_idx_s;
    logic [3:0]             nxt_digit_s;
    logic [1:0]             cur_op_s;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic [1:0] o);
        case (o)
            2'b00:   return 8'h2B;
            2'b01:   return 8'h2D;
            2'b10:   return 8'h2A;
            default: return 8'h2F;
        endcase
    endfunction

    assign out_valid   = (state_q == S_DIGIT) || (state_q == S_OP) || (state_q == S_EQ);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign out_char    = char_q;
    assign hs_s        = out_valid && out_ready;
    assign nxt_idx_s   = idx_q + {{(NT_W-1){1'b0}}, 1'b1};
    assign nxt_digit_s = digits_q[nxt_idx_s*4 +: 4];
    assign cur_op_s    = ops_q[idx_q*2 +: 2];

    // Request validation: only digits below num_terms are range-checked.
    always_comb begin
        req_bad_s = (num_terms == {NT_W{1'b0}}) || (num_terms > NT_W'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            req_bad_s = req_bad_s || ((NT_W'(i) < num_terms) && (digits[4*i +: 4] > 4'd9));
        end
    end

    // Next-state logic; out_char is precomputed for the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nt_d     = nt_q;
        digits_d = digits_q;
        ops_d    = ops_q;
        err_d    = err_q;
        char_d   = char_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nt_d     = num_terms;
                    digits_d = digits;
                    ops_d    = ops;
                    if (req_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        idx_d   = {NT_W{1'b0}};
                        state_d = S_DIGIT;
                        char_d  = digit_char(digits[3:0]);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIGIT: begin
                if (hs_s) begin
                    if (nxt_idx_s == nt_q) begin
                        if (EMIT_EQ) begin
                            state_d = S_EQ;
                            char_d  = 8'h3D;
                        end else begin
                            state_d = S_DONE;
                            char_d  = 8'h00;
                        end
                    end else begin
                        state_d = S_OP;
                        char_d  = op_char(cur_op_s);
                    end
                end else begin
                    state_d = S_DIGIT;
                end
            end
            S_OP: begin
                if (hs_s) begin
                    idx_d   = nxt_idx_s;
                    state_d = S_DIGIT;
                    char_d  = digit_char(nxt_digit_s);
                end else begin
                    state_d = S_OP;
                end
            end
            S_EQ: begin
                if (hs_s) begin
                    state_d = S_DONE;
                    char_d  = 8'h00;
                end else begin
                    state_d = S_EQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                char_d  = 8'h00;
            end
            default: begin
                state_d = S_IDLE;
                char_d  = 8'h00;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            idx_q    <= {NT_W{1'b0}};
            nt_q     <= {NT_W{1'b0}};
            digits_q <= {(4*MAX_TERMS){1'b0}};
            ops_q    <= {OPS_W{1'b0}};
            err_q    <= 1'b0;
            char_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nt_q     <= nt_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            err_q    <= err_d;
            char_q   <= char_d;
        end
    end

endmodule
